// File: rtl/mem_ctrl.sv
// Byte-serial RAM controller arbitrating IF fetches and MEM loads/stores.
// Optional MEM_CTRL_IF_ABORT_EN lets a dropped fetch request abort its read.
module mem_ctrl #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic              if_ack_o,
    output logic [31:0]       if_inst_o,
    input  logic              mem_req_i,
    input  logic              mem_we_i,
    input  logic [ADDR_W-1:0] mem_addr_i,
    input  logic [1:0]        mem_len_i,
    input  logic [31:0]       mem_wdata_i,
    output logic              mem_ack_o,
    output logic [31:0]       mem_rdata_o,
    output logic              stall_req_o,
    output logic [ADDR_W-1:0] ram_a_o,
    output logic              ram_wr_o,
    output logic [7:0]        ram_dout_o,
    input  logic [7:0]        ram_din_i
);

    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_e;

    state_e            state_q;
    logic [ADDR_W-1:0] base_q;
    logic [ADDR_W-1:0] ram_a_q;
    logic              src_if_q;
    logic [2:0]        n_q;
    logic [2:0]        j_q;
    logic [31:0]       wdata_q;
    logic [31:0]       data_q;
    logic              ram_wr_q;
    logic [7:0]        ram_dout_q;
    logic              if_ack_q;
    logic              mem_ack_q;
    logic [31:0]       if_inst_q;
    logic [31:0]       mem_rdata_q;

    logic [2:0]        req_n;
    logic [2:0]        j_nx;
    logic [ADDR_W-1:0] a_nx;
    logic [1:0]        byte_sel;
    logic [31:0]       data_d;
    logic              abort;

    always_comb begin
        unique case (mem_len_i)
            2'd0:    req_n = 3'd1;
            2'd1:    req_n = 3'd2;
            default: req_n = 3'd4;
        endcase
    end

    assign j_nx     = j_q + 3'd1;
    assign a_nx     = base_q + ADDR_W'(j_nx);
    assign byte_sel = j_q[1:0] - 2'd1;

    // RAM data returns one cycle late, so step j carries byte j-1.
    always_comb begin
        data_d = data_q;
        if (state_q == READ && j_q != 3'd0)
            data_d[{byte_sel, 3'b000} +: 8] = ram_din_i;
    end

`ifdef MEM_CTRL_IF_ABORT_EN
    assign abort = src_if_q & ~if_req_i;
`else
    assign abort = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            base_q      <= '0;
            ram_a_q     <= '0;
            src_if_q    <= 1'b0;
            n_q         <= 3'd0;
            j_q         <= 3'd0;
            wdata_q     <= '0;
            data_q      <= '0;
            ram_wr_q    <= 1'b0;
            ram_dout_q  <= '0;
            if_ack_q    <= 1'b0;
            mem_ack_q   <= 1'b0;
            if_inst_q   <= '0;
            mem_rdata_q <= '0;
        end else begin
            if_ack_q  <= 1'b0;
            mem_ack_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (mem_req_i || if_req_i) begin
                        src_if_q <= ~mem_req_i;
                        n_q      <= mem_req_i ? req_n : 3'd4;
                        base_q   <= mem_req_i ? mem_addr_i : if_addr_i;
                        ram_a_q  <= mem_req_i ? mem_addr_i : if_addr_i;
                        wdata_q  <= mem_wdata_i;
                        j_q      <= 3'd0;
                        data_q   <= '0;
                        if (mem_req_i && mem_we_i) begin
                            ram_wr_q   <= 1'b1;
                            ram_dout_q <= mem_wdata_i[7:0];
                            state_q    <= WRITE;
                        end else begin
                            state_q <= READ;
                        end
                    end
                end
                READ: begin
                    data_q <= data_d;
                    j_q    <= j_nx;
                    if (abort) begin
                        state_q <= IDLE;
                    end else if (j_q == n_q) begin
                        state_q <= DONE;
                        if (src_if_q) begin
                            if_ack_q  <= 1'b1;
                            if_inst_q <= data_d;
                        end else begin
                            mem_ack_q   <= 1'b1;
                            mem_rdata_q <= data_d;
                        end
                    end else if (j_nx < n_q) begin
                        ram_a_q <= a_nx;
                    end
                end
                WRITE: begin
                    j_q <= j_nx;
                    if (j_nx == n_q) begin
                        ram_wr_q  <= 1'b0;
                        mem_ack_q <= 1'b1;
                        state_q   <= DONE;
                    end else begin
                        ram_a_q    <= a_nx;
                        ram_dout_q <= wdata_q[{j_nx[1:0], 3'b000} +: 8];
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign if_ack_o    = if_ack_q;
    assign if_inst_o   = if_inst_q;
    assign mem_ack_o   = mem_ack_q;
    assign mem_rdata_o = mem_rdata_q;
    assign ram_a_o     = ram_a_q;
    assign ram_wr_o    = ram_wr_q;
    assign ram_dout_o  = ram_dout_q;
    assign stall_req_o = mem_req_i & ~mem_ack_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Bench for mem_ctrl: transaction-level schedule model plus directed pins.
// Build with MEM_CTRL_IF_ABORT_EN to exercise the fetch-abort variant.
module tb_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        if_req_i = 1'b0;
    logic [31:0] if_addr_i = '0;
    logic        if_ack_o;
    logic [31:0] if_inst_o;
    logic        mem_req_i = 1'b0;
    logic        mem_we_i = 1'b0;
    logic [31:0] mem_addr_i = '0;
    logic [1:0]  mem_len_i = '0;
    logic [31:0] mem_wdata_i = '0;
    logic        mem_ack_o;
    logic [31:0] mem_rdata_o;
    logic        stall_req_o;
    logic [31:0] ram_a_o;
    logic        ram_wr_o;
    logic [7:0]  ram_dout_o;
    logic [7:0]  ram_din_i = '0;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    logic [7:0] ram  [0:65535];
    logic [7:0] mref [0:65535];

    always #5 clk = ~clk;

    mem_ctrl #(.ADDR_W(32)) dut (
        .clk(clk), .rst(rst),
        .if_req_i(if_req_i), .if_addr_i(if_addr_i),
        .if_ack_o(if_ack_o), .if_inst_o(if_inst_o),
        .mem_req_i(mem_req_i), .mem_we_i(mem_we_i),
        .mem_addr_i(mem_addr_i), .mem_len_i(mem_len_i),
        .mem_wdata_i(mem_wdata_i), .mem_ack_o(mem_ack_o),
        .mem_rdata_o(mem_rdata_o), .stall_req_o(stall_req_o),
        .ram_a_o(ram_a_o), .ram_wr_o(ram_wr_o),
        .ram_dout_o(ram_dout_o), .ram_din_i(ram_din_i)
    );

    // Synchronous byte RAM: data appears the cycle after its address.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (ram_wr_o) ram[ram_a_o[15:0]] <= ram_dout_o;
        ram_din_i <= ram[ram_a_o[15:0]];
    end

    function automatic void chk(input string nm, input logic [31:0] got,
                                input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, got, exp);
        end
    endfunction

    task automatic poke(input logic [31:0] a, input logic [7:0] d);
        ram[a[15:0]] <= d;
        mref[a[15:0]] = d;
    endtask

    // Model: per-cycle schedule of expected RAM port activity and acks.
    int          free_at = 0;
    logic [31:0] ea [int];
    bit          ew [int];
    logic [7:0]  ed [int];
    bit          emack [int];
    bit          eiack [int];
    logic [31:0] edata [int];
    bit          if_txn = 0;
    int          if_lo = 0;
    int          if_hi = 0;
    logic [31:0] last_rd = '0;
    logic [31:0] last_in = '0;

    initial forever begin
        int c;
        bit mack, iack, wr;
        @(negedge clk);
        c = cyc;
        if (!rst) begin
            chk("rst_ram_wr", ram_wr_o, 0);
            chk("rst_ram_a", ram_a_o, 0);
            chk("rst_mem_ack", mem_ack_o, 0);
            chk("rst_if_ack", if_ack_o, 0);
            chk("rst_rdata", mem_rdata_o, 0);
            chk("rst_inst", if_inst_o, 0);
            chk("rst_stall", stall_req_o, mem_req_i);
            ea.delete(); ew.delete(); ed.delete();
            emack.delete(); eiack.delete(); edata.delete();
            free_at = c + 1;
            if_txn = 0;
            last_rd = '0;
            last_in = '0;
        end else begin
            mack = emack.exists(c);
            iack = eiack.exists(c);
            wr = ew.exists(c) && ew[c];
            if (mack && edata.exists(c)) last_rd = edata[c];
            if (iack) last_in = edata[c];
            chk("mem_ack", mem_ack_o, mack);
            chk("if_ack", if_ack_o, iack);
            chk("mem_rdata", mem_rdata_o, last_rd);
            chk("if_inst", if_inst_o, last_in);
            chk("ram_wr", ram_wr_o, wr);
            if (ea.exists(c)) chk("ram_a", ram_a_o, ea[c]);
            if (wr) chk("ram_dout", ram_dout_o, ed[c]);
            chk("stall", stall_req_o, mem_req_i & ~mack);
            ea.delete(c); ew.delete(c); ed.delete(c);
            emack.delete(c); eiack.delete(c); edata.delete(c);
`ifdef MEM_CTRL_IF_ABORT_EN
            if (if_txn && c >= if_lo && c <= if_hi && !if_req_i) begin
                for (int k = c + 1; k <= if_hi + 1; k++) begin
                    ea.delete(k); ew.delete(k);
                    eiack.delete(k); edata.delete(k);
                end
                free_at = c + 1;
                if_txn = 0;
            end
`endif
            if (if_txn && c > if_hi) if_txn = 0;
            if (c >= free_at && (mem_req_i || if_req_i)) begin
                logic [31:0] b, a, d;
                int n;
                bit st, isif;
                isif = !mem_req_i;
                b = isif ? if_addr_i : mem_addr_i;
                st = !isif && mem_we_i;
                n = isif ? 4 : (mem_len_i == 0 ? 1 : (mem_len_i == 1 ? 2 : 4));
                d = '0;
                for (int k = 0; k < n; k++) begin
                    a = b + 32'(k);
                    ea[c + 1 + k] = a;
                    ew[c + 1 + k] = st;
                    if (st) begin
                        ed[c + 1 + k] = mem_wdata_i[8*k +: 8];
                        mref[a[15:0]] = mem_wdata_i[8*k +: 8];
                    end else begin
                        d[8*k +: 8] = mref[a[15:0]];
                    end
                end
                if (st) begin
                    emack[c + n + 1] = 1;
                    free_at = c + n + 2;
                end else begin
                    if (isif) eiack[c + n + 2] = 1;
                    else emack[c + n + 2] = 1;
                    edata[c + n + 2] = d;
                    free_at = c + n + 3;
                end
                if (isif) begin
                    if_txn = 1;
                    if_lo = c + 1;
                    if_hi = c + 5;
                end
            end
        end
    end

    task automatic mem_op(input bit we, input logic [31:0] a,
                          input logic [1:0] len, input logic [31:0] wd,
                          output int lat, output logic [31:0] rd);
        int t0;
        bit got;
        @(posedge clk); #1;
        mem_req_i = 1; mem_we_i = we; mem_addr_i = a;
        mem_len_i = len; mem_wdata_i = wd;
        t0 = cyc; got = 0; lat = -1; rd = '0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (mem_ack_o) begin
                got = 1; lat = cyc - t0; rd = mem_rdata_o;
            end
        end
        if (!got) chk("mem_ack_timeout", 0, 1);
        @(posedge clk); #1;
        mem_req_i = 0;
    endtask

    function automatic logic [31:0] raddr();
        if ($urandom_range(0, 7) == 0)
            return 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
        return 32'h3000 + 32'($urandom_range(0, 63));
    endfunction

    task automatic rand_mem(input int iters);
        bit got;
        for (int it = 0; it < iters; it++) begin
            repeat ($urandom_range(1, 4)) @(posedge clk);
            #1;
            mem_we_i = 1'($urandom_range(0, 1));
            mem_addr_i = raddr();
            mem_len_i = 2'($urandom_range(0, 3));
            mem_wdata_i = $urandom;
            mem_req_i = 1;
            got = 0;
            for (int i = 0; i < 60 && !got; i++) begin
                @(negedge clk);
                got = mem_ack_o;
            end
            if (!got) chk("rand_mem_timeout", 0, 1);
            @(posedge clk); #1;
            mem_req_i = 0;
        end
    endtask

    task automatic rand_if(input int iters);
        bit got;
        for (int it = 0; it < iters; it++) begin
            repeat ($urandom_range(1, 5)) @(posedge clk);
            #1;
            if_addr_i = raddr();
            if_req_i = 1;
            if ($urandom_range(0, 4) == 0) begin
                repeat ($urandom_range(1, 8)) @(posedge clk);
                #1;
                if_req_i = 0;
            end else begin
                got = 0;
                for (int i = 0; i < 80 && !got; i++) begin
                    @(negedge clk);
                    got = if_ack_o;
                end
                if (!got) chk("rand_if_timeout", 0, 1);
                @(posedge clk); #1;
                if_req_i = 0;
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1);
    end

    initial begin
        int lat, t0, tm, ti;
        logic [31:0] rd, rdi;
        for (int i = 0; i < 65536; i++) begin
            ram[i] <= 8'(i ^ (i >> 8) ^ 8'hA5);
            mref[i] = 8'(i ^ (i >> 8) ^ 8'hA5);
        end
        poke(32'h100, 8'h11); poke(32'h101, 8'h22);
        poke(32'h102, 8'h33); poke(32'h103, 8'h44);
        poke(32'h2003, 8'h77); poke(32'h2004, 8'h88);
        poke(32'hFFFF_FFFE, 8'hA1); poke(32'hFFFF_FFFF, 8'hB2);
        poke(32'h0, 8'hC3); poke(32'h1, 8'hD4);
        repeat (3) @(posedge clk);
        #1 rst = 1;

        mem_op(0, 32'h100, 2'd2, 32'h0, lat, rd);
        chk("ld_word_lat", lat, 6);
        chk("ld_word_data", rd, 32'h4433_2211);

        mem_op(1, 32'h2001, 2'd1, 32'hDEAD_BEEF, lat, rd);
        chk("st_half_lat", lat, 3);
        chk("st_half_b0", ram[16'h2001], 8'hEF);
        chk("st_half_b1", ram[16'h2002], 8'hBE);
        chk("st_half_keep3", ram[16'h2003], 8'h77);
        chk("st_half_keep4", ram[16'h2004], 8'h88);

        @(posedge clk); #1;
        mem_req_i = 1; mem_we_i = 0; mem_addr_i = 32'h100; mem_len_i = 2'd0;
        if_req_i = 1; if_addr_i = 32'h100;
        t0 = cyc; tm = -1; ti = -1; rd = '0; rdi = '0;
        for (int i = 0; i < 40 && (tm < 0 || ti < 0); i++) begin
            @(negedge clk);
            if (mem_ack_o && tm < 0) begin tm = cyc; rd = mem_rdata_o; end
            if (if_ack_o && ti < 0) begin ti = cyc; rdi = if_inst_o; end
            @(posedge clk); #1;
            if (tm >= 0) mem_req_i = 0;
            if (ti >= 0) if_req_i = 0;
        end
        chk("arb_mem_lat", tm - t0, 3);
        chk("arb_mem_data", rd, 32'h0000_0011);
        chk("arb_if_after_mem", ti - tm, 7);
        chk("arb_if_data", rdi, 32'h4433_2211);

        mem_op(0, 32'hFFFF_FFFE, 2'd3, 32'h0, lat, rd);
        chk("wrap_lat", lat, 6);
        chk("wrap_data", rd, 32'hD4C3_B2A1);

        @(posedge clk); #1;
        mem_req_i = 1; mem_we_i = 1; mem_addr_i = 32'h9000;
        mem_len_i = 2'd2; mem_wdata_i = 32'h1234_5678;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("pre_rst_wr", ram_wr_o, 1);
        #1 rst = 0;
        #1 chk("rst_wr_immediate", ram_wr_o, 0);
        mem_req_i = 0;
        repeat (2) @(posedge clk);
        #1 rst = 1;
        mem_op(0, 32'h100, 2'd0, 32'h0, lat, rd);
        chk("post_rst_lat", lat, 3);
        chk("post_rst_data", rd, 32'h0000_0011);

        @(posedge clk); #1;
        if_req_i = 1; if_addr_i = 32'h100;
        t0 = cyc; tm = -1; ti = -1; rd = '0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (mem_ack_o && tm < 0) begin tm = cyc - t0; rd = mem_rdata_o; end
            if (if_ack_o && ti < 0) ti = cyc - t0;
            @(posedge clk); #1;
            if (cyc == t0 + 3) begin
                if_req_i = 0;
                mem_req_i = 1; mem_we_i = 0;
                mem_addr_i = 32'h2001; mem_len_i = 2'd0;
            end
            if (tm >= 0) mem_req_i = 0;
        end
`ifdef MEM_CTRL_IF_ABORT_EN
        chk("abort_no_if_ack", ti, -1);
        chk("abort_mem_ack_at", tm, 7);
`else
        chk("flush_if_ack_at", ti, 6);
        chk("flush_mem_ack_at", tm, 10);
`endif
        chk("flush_mem_data", rd, 32'h0000_00EF);

        fork
            rand_mem(150);
            rand_if(150);
        join
        repeat (12) @(posedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
